// File: rtl/pwm_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder_if
// Brief    : PWM input and measurement result bundle for pwm_decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_decoder_if #(
    parameter int CNT_WIDTH = 12
);
    logic                 pwm_in;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;
    logic                 valid;
    logic                 timeout;

    modport master (
        output pwm_in,
        input  period,
        input  high_time,
        input  valid,
        input  timeout
    );

    modport slave (
        input  pwm_in,
        output period,
        output high_time,
        output valid,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder
// Brief    : Measures period and high time of an asynchronous PWM input.
//            Optional glitch filter: define PWM_DECODER_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_decoder #(
    parameter int CNT_WIDTH = 12
) (
    input  wire logic    clk,
    input  wire logic    rst,
    pwm_decoder_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_s;
    logic                 r_s_prev;
    logic                 w_rise;
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [CNT_WIDTH-1:0] r_period_cnt;
    logic [CNT_WIDTH-1:0] r_high_cnt;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_high_time;
    logic                 r_valid;
    logic                 r_timeout;
    logic                 w_sat;
    logic                 w_start;
    logic                 w_capture;
    logic                 w_timeout_set;
    logic                 w_count;
    logic                 w_count_high;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    // A new level is accepted only on its third consecutive cycle.
    logic       r_s_filt;
    logic [1:0] r_filt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_filt   <= 1'b0;
            r_filt_cnt <= 2'd0;
        end else if (r_sync2 != r_s_filt) begin
            if (r_filt_cnt == 2'd2) begin
                r_s_filt   <= r_sync2;
                r_filt_cnt <= 2'd0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 2'd1;
            end
        end else begin
            r_filt_cnt <= 2'd0;
        end
    end

    assign w_s = r_s_filt;
`else
    assign w_s = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_prev <= 1'b0;
        end else begin
            r_s_prev <= w_s;
        end
    end

    assign w_rise = w_s & ~r_s_prev;
    assign w_sat  = (r_period_cnt == C_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Saturation wins over a coincident rising edge so counters never wrap.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_rise) w_state_next = S_HIGH;
            S_HIGH: begin
                if (w_sat)       w_state_next = S_IDLE;
                else if (!w_s)   w_state_next = S_LOW;
            end
            S_LOW: begin
                if (w_sat)       w_state_next = S_IDLE;
                else if (w_rise) w_state_next = S_HIGH;
            end
            default:             w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start       = 1'b0;
        w_capture     = 1'b0;
        w_timeout_set = 1'b0;
        w_count       = 1'b0;
        w_count_high  = 1'b0;
        case (r_state)
            S_IDLE: w_start = w_rise;
            S_HIGH: begin
                w_timeout_set = w_sat;
                w_count       = ~w_sat;
                w_count_high  = ~w_sat & w_s;
            end
            S_LOW: begin
                w_timeout_set = w_sat;
                w_capture     = ~w_sat & w_rise;
                w_count       = ~w_sat & ~w_rise;
            end
            default: ;
        endcase
    end

    // The rising-edge cycle is the first cycle of the new period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_start || w_capture) begin
                r_period_cnt <= C_CNT_ONE;
                r_high_cnt   <= C_CNT_ONE;
            end else if (w_count) begin
                r_period_cnt <= r_period_cnt + C_CNT_ONE;
                if (w_count_high) begin
                    r_high_cnt <= r_high_cnt + C_CNT_ONE;
                end
            end
            if (w_capture) begin
                r_period    <= r_period_cnt;
                r_high_time <= r_high_cnt;
                r_timeout   <= 1'b0;
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.period    = r_period;
    assign bus.high_time = r_high_time;
    assign bus.valid     = r_valid;
    assign bus.timeout   = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_decoder
// Brief    : Directed scoreboard bench for pwm_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_decoder;
    localparam int CNT_WIDTH = 12;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    typedef struct packed {
        logic [11:0] p;
        logic [11:0] h;
    } meas_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    meas_t exp_q[$];
    meas_t last_exp;
    int    checks = 0;
    int    errors = 0;
    int    valid_seen = 0;
    int    base;
    bit    armed = 1'b0;
    logic [11:0] prev_p = '0;
    logic [11:0] prev_h = '0;

    always #5 clk = ~clk;

    pwm_decoder_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    pwm_decoder #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [11:0] p, input logic [11:0] h);
        meas_t m;
        m.p = p;
        m.h = h;
        exp_q.push_back(m);
    endtask

    // Each valid pops the oldest expectation; a valid with nothing queued fails.
    always @(negedge clk) begin
        if (!rst && bus.valid === 1'b1) begin
            valid_seen++;
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                last_exp = exp_q.pop_front();
                check("period", 32'(bus.period), 32'(last_exp.p));
                check("high_time", 32'(bus.high_time), 32'(last_exp.h));
            end
        end
    end

    // One PWM period starting with a rising edge; the previous one completes here.
    task automatic pulse(input int p, input int h, input bit lat_chk);
        bit was_armed;
        was_armed = armed;
        if (armed) push(prev_p, prev_h);
        bus.pwm_in = 1'b1;
        for (int i = 1; i <= p; i++) begin
            @(negedge clk);
            bus.pwm_in = (i < h);
            if (lat_chk && was_armed && i == LAT - 1) check("valid_early", 32'(bus.valid), 32'd0);
            if (lat_chk && was_armed && i == LAT)     check("valid_latency", 32'(bus.valid), 32'd1);
        end
        armed  = 1'b1;
        prev_p = 12'(p);
        prev_h = 12'(h);
    endtask

    // 300-cycle high phase with a 2-cycle low glitch at cycles 150..151.
    task automatic glitch_pulse();
        if (armed) push(prev_p, prev_h);
        bus.pwm_in = 1'b1;
        for (int i = 1; i <= 1200; i++) begin
            @(negedge clk);
            bus.pwm_in = (i < 300) && (i != 150) && (i != 151);
`ifndef PWM_DECODER_GLITCH_FILTER_EN
            if (i == 152) push(12'd152, 12'd150);
`endif
        end
        armed = 1'b1;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
        prev_p = 12'd1200;
        prev_h = 12'd300;
`else
        prev_p = 12'd1048;
        prev_h = 12'd148;
`endif
    endtask

    task automatic hold_high(input int n);
        if (armed) push(prev_p, prev_h);
        bus.pwm_in = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 4094 + LAT) check("timeout_before_sat", 32'(bus.timeout), 32'd0);
            if (i == 4095 + LAT) check("timeout_at_sat", 32'(bus.timeout), 32'd1);
        end
        bus.pwm_in = 1'b0;
        armed = 1'b0;
    endtask

    task automatic pulse_with_reset();
        if (armed) push(prev_p, prev_h);
        bus.pwm_in = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            bus.pwm_in = (i < 300);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_period", 32'(bus.period), 32'd0);
        check("rst_mid_high_time", 32'(bus.high_time), 32'd0);
        check("rst_mid_valid", 32'(bus.valid), 32'd0);
        check("rst_mid_timeout", 32'(bus.timeout), 32'd0);
        for (int i = 601; i < 1200; i++) @(negedge clk);
        armed = 1'b0;
    endtask

    initial begin
        bus.pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_period", 32'(bus.period), 32'd0);
        check("reset_high_time", 32'(bus.high_time), 32'd0);
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_timeout", 32'(bus.timeout), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Four edges of a steady 25% waveform give three measurements.
        repeat (4) pulse(1200, 300, 1'b1);
        check("steady_valid_count", 32'(valid_seen), 32'd3);

        repeat (2) pulse(1200, 900, 1'b1);
        pulse(1200, 300, 1'b1);

        glitch_pulse();
        repeat (2) pulse(1200, 300, 1'b1);
        check("queue_drained_glitch", 32'(exp_q.size()), 32'd0);

        base = valid_seen;
        hold_high(5000);
        check("stuck_high_valids", 32'(valid_seen - base), 32'd1);
        repeat (100) @(negedge clk);
        pulse(1200, 300, 1'b0);
        check("timeout_held_first_edge", 32'(bus.timeout), 32'd1);
        pulse(1200, 300, 1'b1);
        check("timeout_cleared", 32'(bus.timeout), 32'd0);

        pulse_with_reset();
        base = valid_seen;
        pulse(1200, 300, 1'b0);
        check("after_rst_first_edge", 32'(valid_seen - base), 32'd0);
        pulse(1200, 300, 1'b1);
        check("after_rst_second_edge", 32'(valid_seen - base), 32'd1);

`ifndef PWM_DECODER_GLITCH_FILTER_EN
        base = valid_seen;
        repeat (6) pulse(2, 1, 1'b0);
        bus.pwm_in = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("fast_valid_count", 32'(valid_seen - base), 32'd6);
`endif

        // Input stuck low: the pending measurement is dropped as a timeout.
        bus.pwm_in = 1'b0;
        repeat (4200) @(negedge clk);
        check("stuck_low_timeout", 32'(bus.timeout), 32'd1);
        check("stuck_low_period_kept", 32'(bus.period), 32'(last_exp.p));
        check("stuck_low_high_kept", 32'(bus.high_time), 32'(last_exp.h));
        check("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 12, giving the width of the period and high-time counters and outputs.
REQ-002 SHALL have port clk  input  1  system clock (12 MHz); the sole clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pwm_in  input  1  asynchronous PWM waveform to measure.
REQ-005 SHALL have port period  output  CNT_WIDTH  clk cycles between the last two synchronized rising edges.
REQ-006 SHALL have port high_time  output  CNT_WIDTH  clk cycles the synchronized input was high within that period.
REQ-007 SHALL have port valid  output  1  one-cycle pulse when period/high_time update.
REQ-008 SHALL have port timeout  output  1  sticky flag: no rising edge within 2^CNT_WIDTH-1 cycles.

Function
REQ-009 SHALL pass pwm_in through a two-flop synchronizer; all logic uses the synchronized value s.
REQ-010 SHALL detect a rising edge as s=1 while the previous-cycle s=0.
REQ-011 SHALL implement states IDLE (await first rising edge), HIGH (s=1), and LOW (s=0 after a high phase).
REQ-012 IDLE -> HIGH on a rising edge, clearing both counters to 1.
REQ-013 HIGH -> LOW when s=0; LOW -> HIGH on a rising edge.
REQ-014 The period counter SHALL increment every cycle in HIGH/LOW; high counter SHALL increment every HIGH cycle.
REQ-015 On a rising edge in LOW: period <= period counter, high_time <= high counter, valid=1 next cycle, counters restart at 1, timeout cleared.
REQ-016 Latency: valid SHALL assert exactly 3 clk cycles after the pwm_in rising edge (filter disabled).
REQ-017 The period counter reaching 2^CNT_WIDTH-1 SHALL force IDLE, set timeout, and leave period/high_time unchanged (covers stuck-high and stuck-low input).
REQ-018 A rising edge in the same cycle the counter saturates SHALL be treated as timeout; no valid.
REQ-019 The first rising edge after reset or timeout SHALL NOT produce valid; the first measurement completes on the second edge.
REQ-020 Counters SHALL never wrap; high_time <= period always.
REQ-021 A high phase of exactly 1 cycle SHALL report high_time=1; a 0% duty input is reported as timeout.

Reset
REQ-022 On rst: state=IDLE, synchronizer flops=0, counters=0, period=0, high_time=0, valid=0, timeout=0.
REQ-023 rst asserted mid-measurement SHALL discard the partial measurement; no valid until two rising edges after release.

Configuration
REQ-024 With PWM_DECODER_GLITCH_FILTER_EN defined, s SHALL change only after the synchronizer output holds a new value for 3 consecutive cycles; shorter pulses are ignored and latency becomes 6 cycles.
REQ-025 Without PWM_DECODER_GLITCH_FILTER_EN, s SHALL equal the second synchronizer flop directly.

Verification
REQ-026 pwm_in period 1200, high 300, repeated 4 times -> valid pulses 3 times, each with period=1200, high_time=300.
REQ-027 Change duty from 300 to 900 mid-stream -> first measurement after the change reports high_time=900, period=1200.
REQ-028 pwm_in held high for 5000 cycles -> timeout=1 at the 4095th counted cycle, no valid; toggling resumes -> timeout clears on the next valid.
REQ-029 rst asserted for 1 cycle at cycle 600 of a 1200-cycle period -> outputs 0; first valid on the second subsequent rising edge.
REQ-030 Filter on: a 2-cycle low glitch inside a 300-cycle high phase -> period=1200, high_time=300; filter off -> extra edge is measured.
REQ-031 Period 2, high 1 -> valid every 2 cycles, period=2, high_time=1.
